// File: rtl/gcn_mem_server_if.sv
// Load stream, row read and COO lookup signals between the GCN core side and gcn_mem_server.
interface gcn_mem_server_if #(
    parameter int WEIGHT_WIDTH  = 5,
    parameter int WEIGHT_ROWS   = 96,
    parameter int ADDRESS_WIDTH = 13,
    parameter int COO_BW        = 3
);
    logic                                load_start;
    logic                                load_valid;
    logic [WEIGHT_WIDTH-1:0]             load_data;
    logic                                load_ready;
    logic                                mem_ready;
    logic                                enable_read;
    logic [ADDRESS_WIDTH-1:0]            read_address;
    logic [WEIGHT_ROWS*WEIGHT_WIDTH-1:0] data_out;
    logic [COO_BW-1:0]                   coo_address;
    logic [2*COO_BW-1:0]                 coo_out;
    logic                                rd_err;

    modport master (
        output load_start, load_valid, load_data, enable_read, read_address, coo_address,
        input  load_ready, mem_ready, data_out, coo_out, rd_err
    );

    modport slave (
        input  load_start, load_valid, load_data, enable_read, read_address, coo_address,
        output load_ready, mem_ready, data_out, coo_out, rd_err
    );
endinterface

// File: rtl/gcn_mem_server.sv
// Register-based memory responder: serially loaded weight/feature/COO storage,
// one-cycle row reads and a COO column lookup every cycle.
module gcn_mem_server #(
    parameter int FEATURE_COLS    = 96,
    parameter int WEIGHT_ROWS     = 96,
    parameter int FEATURE_ROWS    = 6,
    parameter int WEIGHT_COLS     = 3,
    parameter int FEATURE_WIDTH   = 5,
    parameter int WEIGHT_WIDTH    = 5,
    parameter int ADDRESS_WIDTH   = 13,
    parameter int FEATURE_BASE    = 512,
    parameter int COO_NUM_OF_COLS = 6,
    parameter int COO_NUM_OF_ROWS = 2,
    parameter int COO_BW          = $clog2(COO_NUM_OF_COLS)
) (
    input logic clk,
    input logic reset,
    gcn_mem_server_if.slave bus
);
    localparam int ROW_BITS = WEIGHT_ROWS * WEIGHT_WIDTH;
    localparam int EW       = $clog2(WEIGHT_ROWS);
    localparam int MAX_ROWS = (FEATURE_ROWS > WEIGHT_COLS) ? FEATURE_ROWS : WEIGHT_COLS;
    localparam int RW       = $clog2(MAX_ROWS > COO_NUM_OF_ROWS ? MAX_ROWS : COO_NUM_OF_ROWS);
    localparam int WIW      = $clog2(WEIGHT_COLS);
    localparam int FIW      = $clog2(FEATURE_ROWS);

    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_F, LOAD_C, READY} state_t;

    state_t r_state, w_state_next;
    logic [EW-1:0] r_elem_cnt;
    logic [RW-1:0] r_row_cnt;

    logic [WEIGHT_WIDTH-1:0]  r_weight  [WEIGHT_COLS][WEIGHT_ROWS];
    logic [FEATURE_WIDTH-1:0] r_feature [FEATURE_ROWS][FEATURE_COLS];
    logic [COO_BW-1:0]        r_coo     [COO_NUM_OF_ROWS][COO_NUM_OF_COLS];

    logic [ROW_BITS-1:0] r_data_out;
    logic [2*COO_BW-1:0] r_coo_out;
    logic                r_rd_err;
    logic                r_mem_ready;

    logic                w_loading, w_accept, w_row_end, w_phase_end;
    logic [EW-1:0]       w_row_last;
    logic [RW-1:0]       w_rows_last;
    logic [ROW_BITS-1:0] w_weight_rows  [WEIGHT_COLS];
    logic [ROW_BITS-1:0] w_feature_rows [FEATURE_ROWS];
    logic [ROW_BITS-1:0] w_rd_row;
    logic                w_rd_hit, w_rd_ok;
    logic [2*COO_BW-1:0] w_coo_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, READY: if (bus.load_start) w_state_next = LOAD_W;
            LOAD_W: if (bus.load_start) w_state_next = LOAD_W;
                    else if (w_phase_end) w_state_next = LOAD_F;
            LOAD_F: if (bus.load_start) w_state_next = LOAD_W;
                    else if (w_phase_end) w_state_next = LOAD_C;
            LOAD_C: if (bus.load_start) w_state_next = LOAD_W;
                    else if (w_phase_end) w_state_next = READY;
            default: w_state_next = IDLE;
        endcase
    end

    // Row length and row count depend on which table is being filled.
    always_comb begin
        w_loading   = (r_state == LOAD_W) || (r_state == LOAD_F) || (r_state == LOAD_C);
        w_row_last  = '0;
        w_rows_last = '0;
        case (r_state)
            LOAD_W: begin w_row_last = EW'(WEIGHT_ROWS - 1);     w_rows_last = RW'(WEIGHT_COLS - 1);     end
            LOAD_F: begin w_row_last = EW'(FEATURE_COLS - 1);    w_rows_last = RW'(FEATURE_ROWS - 1);    end
            LOAD_C: begin w_row_last = EW'(COO_NUM_OF_COLS - 1); w_rows_last = RW'(COO_NUM_OF_ROWS - 1); end
            default: ;
        endcase
        w_accept       = w_loading && bus.load_valid && !bus.load_start;
        w_row_end      = (r_elem_cnt == w_row_last);
        w_phase_end    = w_accept && w_row_end && (r_row_cnt == w_rows_last);
        bus.load_ready = w_loading;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_elem_cnt <= '0;
            r_row_cnt  <= '0;
        end else if (bus.load_start) begin
            r_elem_cnt <= '0;
            r_row_cnt  <= '0;
        end else if (w_accept) begin
            if (w_row_end) begin
                r_elem_cnt <= '0;
                r_row_cnt  <= (r_row_cnt == w_rows_last) ? '0 : r_row_cnt + 1'b1;
            end else begin
                r_elem_cnt <= r_elem_cnt + 1'b1;
            end
        end
    end

    // Storage keeps its contents across reset; only the load stream writes it.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            case (r_state)
                LOAD_W: r_weight[r_row_cnt[WIW-1:0]][r_elem_cnt] <= bus.load_data;
                LOAD_F: r_feature[r_row_cnt[FIW-1:0]][r_elem_cnt] <= bus.load_data;
                LOAD_C: r_coo[r_row_cnt[0]][r_elem_cnt[COO_BW-1:0]] <= bus.load_data[COO_BW-1:0];
                default: ;
            endcase
        end
    end

    // Element 0 lands in the most significant slice of a returned row.
    for (genvar gi = 0; gi < WEIGHT_COLS; gi++) begin : g_wrow
        for (genvar gk = 0; gk < WEIGHT_ROWS; gk++) begin : g_welem
            assign w_weight_rows[gi][(WEIGHT_ROWS-1-gk)*WEIGHT_WIDTH +: WEIGHT_WIDTH] = r_weight[gi][gk];
        end
    end
    for (genvar gi = 0; gi < FEATURE_ROWS; gi++) begin : g_frow
        for (genvar gk = 0; gk < FEATURE_COLS; gk++) begin : g_felem
            assign w_feature_rows[gi][(FEATURE_COLS-1-gk)*FEATURE_WIDTH +: FEATURE_WIDTH] = r_feature[gi][gk];
        end
    end

    always_comb begin
        w_rd_row = '0;
        w_rd_hit = 1'b0;
        for (int c = 0; c < WEIGHT_COLS; c++) begin
            if (bus.read_address == ADDRESS_WIDTH'(c)) begin
                w_rd_row = w_weight_rows[c];
                w_rd_hit = 1'b1;
            end
        end
        for (int f = 0; f < FEATURE_ROWS; f++) begin
            if (bus.read_address == ADDRESS_WIDTH'(FEATURE_BASE + f)) begin
                w_rd_row = w_feature_rows[f];
                w_rd_hit = 1'b1;
            end
        end
        w_rd_ok = w_rd_hit && (r_state == READY);
        w_coo_next = '0;
        for (int a = 0; a < COO_NUM_OF_COLS; a++) begin
            if (bus.coo_address == COO_BW'(a)) w_coo_next = {r_coo[0][a], r_coo[1][a]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data_out  <= '0;
            r_coo_out   <= '0;
            r_rd_err    <= 1'b0;
            r_mem_ready <= 1'b0;
        end else begin
            r_coo_out <= w_coo_next;
            if (bus.enable_read) r_data_out <= w_rd_ok ? w_rd_row : '0;
            if (bus.load_start)                       r_rd_err <= 1'b0;
            else if (bus.enable_read && !w_rd_ok)     r_rd_err <= 1'b1;
            if (bus.load_start)                              r_mem_ready <= 1'b0;
            else if (r_state == LOAD_C && w_phase_end)       r_mem_ready <= 1'b1;
        end
    end

    assign bus.data_out  = r_data_out;
    assign bus.coo_out   = r_coo_out;
    assign bus.rd_err    = r_rd_err;
    assign bus.mem_ready = r_mem_ready;
endmodule

// File: tb/tb_gcn_mem_server.sv
// Randomized scoreboard bench for gcn_mem_server against a table-level memory model.
module tb_gcn_mem_server;
    localparam int WW = 5, WR = 96, WC = 3, FR = 6, FC = 96, AW = 13, FB = 512;
    localparam int CN = 6, CBW = 3, ROWB = WR * WW;
    localparam int NW = WC * WR, NF = FR * FC, NTOT = NW + NF + 2 * CN;

    logic clk, reset;
    gcn_mem_server_if #(.WEIGHT_WIDTH(WW), .WEIGHT_ROWS(WR), .ADDRESS_WIDTH(AW), .COO_BW(CBW)) bus ();
    gcn_mem_server dut (.clk(clk), .reset(reset), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit              is_rd;
        logic [ROWB-1:0] row;
        bit              err;
        bit              is_coo;
        logic [2*CBW-1:0] coo;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0, n_errors = 0;
    bit   coo_chk = 0;

    int   vals [NTOT];
    int   w_m [WC][WR];
    int   f_m [FR][FC];
    int   c_m [2][CN];
    bit   m_ready = 0, m_err = 0;

    task automatic chk(input string name, input logic [ROWB-1:0] act, input logic [ROWB-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: whenever a read or COO check was presented at an edge, compare after it.
    initial begin
        exp_t e;
        bit rd_s, cc_s;
        forever begin
            @(posedge clk);
            rd_s = bus.enable_read;
            cc_s = coo_chk;
            if (rd_s || cc_s) begin
                @(negedge clk);
                if (q.size() == 0) begin
                    chk("sb_empty", 1, 0);
                end else begin
                    e = q.pop_front();
                    if (e.is_rd) begin
                        chk("data_out", bus.data_out, e.row);
                        chk("rd_err", ROWB'(bus.rd_err), ROWB'(e.err));
                    end
                    if (e.is_coo) chk("coo_out", ROWB'(bus.coo_out), ROWB'(e.coo));
                end
            end
        end
    end

    function automatic logic [ROWB-1:0] model_row(input int addr, output bit ok);
        logic [ROWB-1:0] r = '0;
        ok = 0;
        if (addr < WC) begin
            ok = 1;
            for (int k = 0; k < WR; k++) r[(WR-1-k)*WW +: WW] = WW'(w_m[addr][k]);
        end else if (addr >= FB && addr < FB + FR) begin
            ok = 1;
            for (int k = 0; k < FC; k++) r[(FC-1-k)*WW +: WW] = WW'(f_m[addr-FB][k]);
        end
        return r;
    endfunction

    // Drive one read and/or COO request for the coming edge and record what it must return.
    task automatic present(input bit do_rd, input int addr, input bit do_coo, input int caddr);
        exp_t e;
        bit ok;
        e.is_rd = do_rd; e.is_coo = do_coo; e.row = '0; e.err = 0; e.coo = '0;
        bus.enable_read  = do_rd;
        bus.read_address = AW'(addr);
        bus.coo_address  = CBW'(caddr);
        coo_chk          = do_coo;
        if (do_rd) begin
            e.row = model_row(addr, ok);
            if (!ok || !m_ready) begin
                e.row = '0;
                m_err = 1;
            end
            e.err = m_err;
        end
        if (do_coo && caddr < CN) e.coo = {CBW'(c_m[0][caddr]), CBW'(c_m[1][caddr])};
        if (do_rd || do_coo) q.push_back(e);
    endtask

    task automatic issue(input bit do_rd, input int addr, input bit do_coo, input int caddr);
        present(do_rd, addr, do_coo, caddr);
        @(posedge clk); #2;
        bus.enable_read = 0;
        coo_chk = 0;
    endtask

    task automatic pulse_start();
        bus.load_start = 1;
        bus.load_valid = 0;
        @(posedge clk); #2;
        bus.load_start = 0;
        m_ready = 0;
        m_err = 0;
        chk("start_load_ready", ROWB'(bus.load_ready), ROWB'(1));
        chk("start_mem_ready", ROWB'(bus.mem_ready), ROWB'(0));
        chk("start_rd_err", ROWB'(bus.rd_err), ROWB'(0));
    endtask

    function automatic void build_vals(input bit rnd);
        int cp [12] = '{0, 0, 1, 2, 3, 4, 1, 5, 2, 3, 4, 5};
        for (int r = 0; r < WC; r++)
            for (int k = 0; k < WR; k++) vals[r*WR+k] = rnd ? int'($urandom_range(0, 31)) : (r*96 + k) % 32;
        for (int r = 0; r < FR; r++)
            for (int k = 0; k < FC; k++) vals[NW+r*FC+k] = rnd ? int'($urandom_range(0, 31)) : (r + k) % 32;
        for (int i = 0; i < 2*CN; i++) vals[NW+NF+i] = rnd ? int'($urandom_range(0, 31)) : cp[i];
    endfunction

    function automatic void commit_model();
        for (int r = 0; r < WC; r++) for (int k = 0; k < WR; k++) w_m[r][k] = vals[r*WR+k];
        for (int r = 0; r < FR; r++) for (int k = 0; k < FC; k++) f_m[r][k] = vals[NW+r*FC+k];
        for (int i = 0; i < 2*CN; i++) c_m[i/CN][i%CN] = vals[NW+NF+i] % (1 << CBW);
    endfunction

    // Feed elements [0, n) of the planned stream; valid is asserted with probability pct%.
    task automatic stream(input int n, input int pct, input bit final_rd);
        int acc = 0, cyc = 0;
        bit v;
        while (acc < n && cyc < 20000) begin
            v = ($urandom_range(0, 99) < pct);
            bus.load_valid = v;
            bus.load_data  = WW'(vals[acc]);
            if (final_rd && v && acc == NTOT - 1) present(1, 0, 0, 0);
            @(posedge clk); #2;
            cyc++;
            bus.enable_read = 0;
            if (v) acc++;
            if (acc == NTOT && v) begin
                m_ready = 1;
                commit_model();
            end
            chk("mem_ready", ROWB'(bus.mem_ready), ROWB'(acc == NTOT));
            chk("load_ready", ROWB'(bus.load_ready), ROWB'(acc < NTOT));
        end
        if (acc < n) chk("stream_timeout", ROWB'(acc), ROWB'(n));
        bus.load_valid = 0;
    endtask

    initial begin
        int a;
        bus.load_start = 0; bus.load_valid = 0; bus.load_data = '0;
        bus.enable_read = 0; bus.read_address = '0; bus.coo_address = '0;
        for (int i = 0; i < 2*CN; i++) c_m[i/CN][i%CN] = 0;
        reset = 0;
        repeat (3) @(posedge clk);
        #2 reset = 1;
        chk("rst_load_ready", ROWB'(bus.load_ready), ROWB'(0));
        chk("rst_mem_ready", ROWB'(bus.mem_ready), ROWB'(0));
        chk("rst_data_out", bus.data_out, '0);
        chk("rst_rd_err", ROWB'(bus.rd_err), ROWB'(0));

        // Idle ignores load_valid; a read before loading is an error.
        bus.load_valid = 1;
        issue(1, 0, 0, 0);
        bus.load_valid = 0;
        chk("idle_load_ready", ROWB'(bus.load_ready), ROWB'(0));

        // Partial load, then asynchronous reset mid-stream.
        build_vals(1);
        pulse_start();
        stream(100, 100, 0);
        #1 reset = 0;
        #1;
        chk("midrst_load_ready", ROWB'(bus.load_ready), ROWB'(0));
        chk("midrst_mem_ready", ROWB'(bus.mem_ready), ROWB'(0));
        chk("midrst_rd_err", ROWB'(bus.rd_err), ROWB'(0));
        chk("midrst_data_out", bus.data_out, '0);
        chk("midrst_coo_out", ROWB'(bus.coo_out), '0);
        m_err = 0;
        @(posedge clk); #2 reset = 1;

        // Known-pattern load, then directed reads.
        build_vals(0);
        pulse_start();
        stream(NTOT, 100, 0);
        issue(1, 2, 1, 3);
        issue(1, 517, 1, 7);
        present(1, 0, 0, 0);   @(posedge clk); #2;
        present(1, 512, 1, 0); @(posedge clk); #2;
        present(1, 1, 1, 5);   @(posedge clk); #2;
        present(1, 513, 1, 1); @(posedge clk); #2;
        bus.enable_read = 0; coo_chk = 0;
        chk("good_rd_err", ROWB'(bus.rd_err), ROWB'(0));
        issue(1, 3, 0, 0);
        issue(1, 518, 0, 0);
        issue(1, 100, 0, 0);
        issue(1, 1, 1, 2);
        repeat (3) @(posedge clk);
        #1 chk("sticky_rd_err", ROWB'(bus.rd_err), ROWB'(1));

        // Random load with a restart in the feature phase, then a full random reload.
        build_vals(1);
        pulse_start();
        stream(NW + 20, 50, 0);
        pulse_start();
        stream(NTOT, 50, 1);
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 3))
                0: a = int'($urandom_range(0, WC-1));
                1: a = FB + int'($urandom_range(0, FR-1));
                2: a = int'($urandom_range(0, 8191));
                default: a = FB + int'($urandom_range(0, FR-1));
            endcase
            issue($urandom_range(0, 3) != 0, a, 1, int'($urandom_range(0, 7)));
        end

        // One last clean load to exercise error-free random reads.
        pulse_start();
        stream(NTOT, 70, 0);
        for (int t = 0; t < 30; t++) begin
            a = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, WC-1)) : FB + int'($urandom_range(0, FR-1));
            issue(1, a, 1, int'($urandom_range(0, 7)));
        end
        repeat (3) @(posedge clk);
        chk("sb_drained", ROWB'(q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, expected finish before 2000000");
        $fatal(1, "timeout");
    end
endmodule
